spi_master_arbiter: RTL and testbench
=====================================

Name: spi_master_arbiter

Overview:
- Shares one SPI master bus between N_REQ on-chip requesters, one slave chip-select per requester.
- Arbitrates requests round-robin and generates the SPI clock from the system clock.
- Runs one DATA_W-bit full-duplex mode-0 frame per grant, then returns the received word to the granted requester.
- Sits between the control logic and the board-level SPI slaves, including the team's spi slave cores.

Parameters:
- N_REQ, 4, number of requesters and chip selects; legal range 2..8.
- DATA_W, 8, frame length in bits, MSB first.
- CLK_DIV, 2, SPI half-period in sclk cycles; must be ≥1.

Ports:
- sclk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- req  in  N_REQ  level request, one bit per requester.
- tx_data  in  N_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W].
- gnt  out  N_REQ  one-hot grant, held for the whole frame.
- done  out  N_REQ  one-cycle pulse to the granted requester at frame end.
- rx_data  out  DATA_W  received word; valid while done is high, held until the next frame end.
- busy  out  1  high in every state except IDLE.
- spi_clk  out  1  SPI clock, idle low.
- mosi  out  1  master data out.
- miso  in  1  slave data in; undriven (z) is sampled as 0.
- cs_n  out  N_REQ  active-low chip selects; at most one low at any time.

Behaviour:
- Reset values (asynchronous): gnt=0, done=0, rx_data=0, busy=0, spi_clk=0, mosi=0, cs_n=all 1, rr pointer=N_REQ-1, FSM=IDLE.
- Reset asserted mid-frame aborts immediately, with no done pulse.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- IDLE:
  - If any req is set, pick the winner k as the first set bit searching upward from (ptr+1) mod N_REQ, with wrap-around.
  - Next cycle: gnt[k]=1, cs_n[k]=0, ptr=k, shift register loaded from tx_data[k], mosi=bit DATA_W-1, go to SETUP.
  - Latency from req high in IDLE to cs_n low is 1 cycle.
- SETUP: spi_clk=0 for CLK_DIV cycles, then go to HIGH.
- HIGH:
  - spi_clk=1 for CLK_DIV cycles.
  - miso is sampled into the rx shift register (shift left, LSB in) on the first HIGH cycle (the rising edge).
  - After CLK_DIV cycles: if bit counter = DATA_W-1 go to HOLD, else go to LOW.
- LOW: spi_clk=0 for CLK_DIV cycles; on entry mosi advances to the next lower bit and the bit counter increments; then go to HIGH.
- HOLD: spi_clk=0 and cs_n still low for CLK_DIV cycles, then go to GAP.
- GAP (entry cycle):
  - cs_n goes all 1, gnt goes 0.
  - done[k] pulses for 1 cycle and rx_data updates with the full word.
- GAP (duration): CLK_DIV cycles minimum with cs_n high; mosi=0; then go to IDLE.
- Frame length from grant to done: CLK_DIV*(2*DATA_W+1) cycles. Default: 34 cycles.
- req deasserted mid-frame is ignored; the frame completes and done still pulses.
- tx_data is captured at grant only; later changes have no effect.
- Requester holding req after done: eligible again, but after any other pending requester (fairness).
- Only one req set: it is granted back-to-back, separated by GAP plus 1 IDLE cycle.
- Bit counter width is clog2(DATA_W); never wraps within a frame.

Optional Feature:
- Macro: SPI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; ptr is unused and held at reset value.
- Undefined (default): round-robin as described above.

Test Plan:
- Single request, loopback miso=mosi: req=4'b0001, tx_data[0]=8'hA5, CLK_DIV=2 -> cs_n=4'b1110 for the frame, 8 spi_clk rising edges, mosi MSB-first 1,0,1,0,0,1,0,1, done=4'b0001 at cycle 34, rx_data=8'hA5.
- Slave pattern: miso returns 8'h3C on rising edges to requester 2 -> rx_data=8'h3C with done[2].
- All four requesting continuously -> grant order 0,1,2,3,0; never two cs_n low; each done matches the preceding gnt.
- Reset asserted in the 4th HIGH phase -> outputs at reset values within the same cycle, no done, next frame after release starts cleanly from ptr=3 (requester 0 first).
- req[1] dropped after 3 bits -> frame still finishes, done[1] pulses, no re-grant to 1.
- With SPI_ARB_FIXED_PRIO_EN defined and req=4'b0110 held -> requester 1 granted every time, requester 2 starves.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin shared SPI mode-0 master, one chip select per requester
// Build option: define SPI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module spi_master_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic                    sclk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] tx_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [DATA_W-1:0]       rx_data,
    output logic                    busy,
    output logic                    spi_clk,
    output logic                    mosi,
    input  logic                    miso,
    output logic [N_REQ-1:0]        cs_n
);
    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(DATA_W);
    localparam int CW = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [N_REQ-1:0]    cs_n_q, cs_n_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-2:0]   tx_sh_q, tx_sh_d;
    logic                spi_clk_q, spi_clk_d;
    logic                mosi_q, mosi_d;
    logic [PW-1:0]       idx, win;
    logic                hit;
    logic                last;
    logic [DATA_W-1:0]   word;

    assign last    = cnt_q == CW'(CLK_DIV - 1);
    assign word    = tx_data[win*DATA_W +: DATA_W];
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign busy    = state_q != IDLE;
    assign spi_clk = spi_clk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

    // Pick the winning requester: first set bit after ptr (round-robin) or lowest index (fixed)
    always_comb begin
        idx = '0;
        win = '0;
        hit = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
            idx = PW'(i);
`else
            idx = PW'((int'(ptr_q) + 1 + i) % N_REQ);
`endif
            if (!hit && req[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
    end

    // Frame sequencer: next state and registered bus outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
        bit_d     = bit_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        cs_n_d    = cs_n_q;
        rx_d      = rx_q;
        rx_sh_d   = rx_sh_q;
        tx_sh_d   = tx_sh_q;
        spi_clk_d = spi_clk_q;
        mosi_d    = mosi_q;
        case (state_q)
            IDLE: if (hit) begin
                state_d = SETUP;
                gnt_d   = N_REQ'(1) << win;
                cs_n_d  = ~(N_REQ'(1) << win);
`ifndef SPI_ARB_FIXED_PRIO_EN
                ptr_d   = win;
`endif
                mosi_d  = word[DATA_W-1];
                tx_sh_d = word[DATA_W-2:0];
                rx_sh_d = '0;
                bit_d   = '0;
            end
            SETUP: if (last) begin
                state_d   = HIGH;
                spi_clk_d = 1'b1;
            end
            HIGH: begin
                if (cnt_q == '0)
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], miso === 1'b1};
                if (last) begin
                    spi_clk_d = 1'b0;
                    if (bit_q == BW'(DATA_W - 1))
                        state_d = HOLD;
                    else begin
                        state_d = LOW;
                        bit_d   = bit_q + 1'b1;
                        mosi_d  = tx_sh_q[DATA_W-2];
                        tx_sh_d = tx_sh_q << 1;
                    end
                end
            end
            LOW: if (last) begin
                state_d   = HIGH;
                spi_clk_d = 1'b1;
            end
            HOLD: if (last) begin
                state_d = GAP;
                cs_n_d  = '1;
                gnt_d   = '0;
                done_d  = gnt_q;
                rx_d    = rx_sh_q;
                mosi_d  = 1'b0;
            end
            GAP: if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous abort
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            ptr_q     <= PW'(N_REQ - 1);
            gnt_q     <= '0;
            done_q    <= '0;
            cs_n_q    <= '1;
            rx_q      <= '0;
            rx_sh_q   <= '0;
            tx_sh_q   <= '0;
            spi_clk_q <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            rx_q      <= rx_d;
            rx_sh_q   <= rx_sh_d;
            tx_sh_q   <= tx_sh_d;
            spi_clk_q <= spi_clk_d;
            mosi_q    <= mosi_d;
        end
    end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed scenario bench for spi_master_arbiter (default parameters)
module tb_spi_master_arbiter;
    logic        sclk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] tx_data = '0;
    logic [3:0]  gnt, done, cs_n;
    logic [7:0]  rx_data;
    logic        busy, spi_clk, mosi;
    logic        miso = 1'b0;

    int checks = 0;
    int errors = 0;

    logic       obs_ok, obs_multi;
    int         obs_wait, obs_len, obs_rises;
    logic [3:0] obs_gnt, obs_cs, obs_done;
    logic [7:0] obs_mosi, obs_rx;

    spi_master_arbiter dut (
        .sclk(sclk), .reset(reset), .req(req), .tx_data(tx_data), .gnt(gnt), .done(done),
        .rx_data(rx_data), .busy(busy), .spi_clk(spi_clk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 sclk = ~sclk;

    // Follows one frame from cs_n low to done, acting as slave; records observations only
    task automatic observe(input logic lb, input logic [7:0] pat, input logic [3:0] req_after,
                           input int drop_at, input logic [31:0] tx_after);
        int falls;
        logic prev_clk, applied;
        obs_ok = 0; obs_multi = 0; obs_wait = 0; obs_len = 0; obs_rises = 0;
        obs_gnt = 0; obs_cs = 0; obs_done = 0; obs_mosi = 0; obs_rx = 0;
        falls = 0; applied = 0;
        for (int w = 1; w <= 200 && obs_wait == 0; w++) begin
            @(negedge sclk);
            if (cs_n !== 4'hF) obs_wait = w;
        end
        if (obs_wait == 0) return;
        obs_gnt = gnt; obs_cs = cs_n; prev_clk = spi_clk;
        if (drop_at == 0) begin req = req_after; tx_data = tx_after; applied = 1; end
        miso = lb ? mosi : pat[7];
        for (int n = 1; n <= 200 && !obs_ok; n++) begin
            @(negedge sclk);
            if (spi_clk && !prev_clk) begin obs_rises++; obs_mosi = {obs_mosi[6:0], mosi}; end
            if (!spi_clk && prev_clk) falls++;
            prev_clk = spi_clk;
            if (!applied && obs_rises == drop_at) begin req = req_after; tx_data = tx_after; applied = 1; end
            if ($countones(~cs_n) > 1) obs_multi = 1;
            miso = lb ? mosi : (falls < 8 ? pat[7 - falls] : 1'b0);
            if (done != 0) begin obs_ok = 1; obs_done = done; obs_rx = rx_data; obs_len = n; end
        end
        miso = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sclk);
        checks++; if (gnt !== 4'h0)    begin errors++; $display("FAIL reset_gnt got %h exp 0", gnt); end
        checks++; if (done !== 4'h0)   begin errors++; $display("FAIL reset_done got %h exp 0", done); end
        checks++; if (rx_data !== 8'h0) begin errors++; $display("FAIL reset_rx got %h exp 0", rx_data); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_spi_clk got %b exp 0", spi_clk); end
        checks++; if (mosi !== 1'b0)   begin errors++; $display("FAIL reset_mosi got %b exp 0", mosi); end
        checks++; if (cs_n !== 4'hF)   begin errors++; $display("FAIL reset_cs_n got %h exp f", cs_n); end
        reset = 1'b0;
    endtask

    task automatic test_loopback();
        @(negedge sclk);
        req = 4'b0001; tx_data = 32'h000000A5;
        observe(1'b1, 8'h00, 4'b0000, 0, 32'h000000A5);
        checks++; if (obs_wait !== 1)      begin errors++; $display("FAIL lb_latency got %0d exp 1", obs_wait); end
        checks++; if (obs_cs !== 4'b1110)  begin errors++; $display("FAIL lb_cs_n got %h exp e", obs_cs); end
        checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL lb_gnt got %h exp 1", obs_gnt); end
        checks++; if (obs_rises !== 8)     begin errors++; $display("FAIL lb_rises got %0d exp 8", obs_rises); end
        checks++; if (obs_mosi !== 8'hA5)  begin errors++; $display("FAIL lb_mosi got %h exp a5", obs_mosi); end
        checks++; if (obs_done !== 4'b0001) begin errors++; $display("FAIL lb_done got %h exp 1", obs_done); end
        checks++; if (obs_len !== 34)      begin errors++; $display("FAIL lb_len got %0d exp 34", obs_len); end
        checks++; if (obs_rx !== 8'hA5)    begin errors++; $display("FAIL lb_rx got %h exp a5", obs_rx); end
        @(negedge sclk);
        checks++; if (done !== 4'h0)    begin errors++; $display("FAIL lb_done_pulse got %h exp 0", done); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL lb_rx_hold got %h exp a5", rx_data); end
        checks++; if (cs_n !== 4'hF)    begin errors++; $display("FAIL lb_gap_cs_n got %h exp f", cs_n); end
        checks++; if (mosi !== 1'b0)    begin errors++; $display("FAIL lb_gap_mosi got %b exp 0", mosi); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL lb_gap_busy got %b exp 1", busy); end
        @(negedge sclk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL lb_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_slave();
        @(negedge sclk);
        req = 4'b0100; tx_data = 32'h005A0000;
        observe(1'b0, 8'h3C, 4'b0000, 0, 32'h00FF0000);
        checks++; if (obs_ok !== 1'b1)     begin errors++; $display("FAIL sl_timeout got %b exp 1", obs_ok); end
        checks++; if (obs_cs !== 4'b1011)  begin errors++; $display("FAIL sl_cs_n got %h exp b", obs_cs); end
        checks++; if (obs_mosi !== 8'h5A)  begin errors++; $display("FAIL sl_tx_capture got %h exp 5a", obs_mosi); end
        checks++; if (obs_done !== 4'b0100) begin errors++; $display("FAIL sl_done got %h exp 4", obs_done); end
        checks++; if (obs_rx !== 8'h3C)    begin errors++; $display("FAIL sl_rx got %h exp 3c", obs_rx); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] exp_w [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        @(negedge sclk); reset = 1'b1;
        @(negedge sclk); reset = 1'b0;
        req = 4'hF; tx_data = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            observe(1'b1, 8'h00, (i == 4) ? 4'h0 : 4'hF, 0, 32'h44332211);
            checks++; if (obs_gnt !== exp_g[i])  begin errors++; $display("FAIL rr_gnt%0d got %h exp %h", i, obs_gnt, exp_g[i]); end
            checks++; if (obs_done !== exp_g[i]) begin errors++; $display("FAIL rr_done%0d got %h exp %h", i, obs_done, exp_g[i]); end
            checks++; if (obs_rx !== exp_w[i])   begin errors++; $display("FAIL rr_rx%0d got %h exp %h", i, obs_rx, exp_w[i]); end
            checks++; if (obs_multi !== 1'b0)    begin errors++; $display("FAIL rr_cs_onehot%0d got %b exp 0", i, obs_multi); end
        end
    endtask

    task automatic test_fixed_prio();
        @(negedge sclk);
        req = 4'b0110; tx_data = 32'h00C3A500;
        for (int i = 0; i < 3; i++) begin
            observe(1'b1, 8'h00, (i == 2) ? 4'h0 : 4'b0110, 0, 32'h00C3A500);
            checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL fp_gnt%0d got %h exp 2", i, obs_gnt); end
            checks++; if (obs_rx !== 8'hA5)    begin errors++; $display("FAIL fp_rx%0d got %h exp a5", i, obs_rx); end
        end
    endtask

    task automatic test_reset_mid();
        int rises = 0;
        logic prev = 1'b0, seen_done = 1'b0, low = 1'b0;
        @(negedge sclk);
        req = 4'b0010; tx_data = 32'h0000F000;
        for (int n = 0; n < 300 && rises < 4; n++) begin
            @(negedge sclk);
            if (cs_n !== 4'hF) low = 1'b1;
            if (low && spi_clk && !prev) rises++;
            if (done != 0) seen_done = 1'b1;
            prev = spi_clk;
        end
        checks++; if (rises !== 4) begin errors++; $display("FAIL rm_reach_high4 got %0d exp 4", rises); end
        reset = 1'b1; req = 4'b0000;
        #1;
        checks++; if (cs_n !== 4'hF)   begin errors++; $display("FAIL rm_cs_n got %h exp f", cs_n); end
        checks++; if (gnt !== 4'h0)    begin errors++; $display("FAIL rm_gnt got %h exp 0", gnt); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rm_spi_clk got %b exp 0", spi_clk); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
        checks++; if (mosi !== 1'b0)   begin errors++; $display("FAIL rm_mosi got %b exp 0", mosi); end
        checks++; if (rx_data !== 8'h0) begin errors++; $display("FAIL rm_rx got %h exp 0", rx_data); end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rm_no_done got %b exp 0", seen_done); end
        @(negedge sclk); reset = 1'b0;
        req = 4'b1001; tx_data = 32'h690000_96;
        observe(1'b1, 8'h00, 4'b0000, 0, 32'h69000096);
        checks++; if (obs_gnt !== 4'b0001)  begin errors++; $display("FAIL rm_restart_gnt got %h exp 1", obs_gnt); end
        checks++; if (obs_rx !== 8'h96)     begin errors++; $display("FAIL rm_restart_rx got %h exp 96", obs_rx); end
    endtask

    task automatic test_req_drop();
        logic regrant = 1'b0;
        @(negedge sclk);
        req = 4'b0010; tx_data = 32'h00003C00;
        observe(1'b1, 8'h00, 4'b0000, 3, 32'h00003C00);
        checks++; if (obs_done !== 4'b0010) begin errors++; $display("FAIL rd_done got %h exp 2", obs_done); end
        checks++; if (obs_rx !== 8'h3C)     begin errors++; $display("FAIL rd_rx got %h exp 3c", obs_rx); end
        for (int n = 0; n < 12; n++) begin
            @(negedge sclk);
            if (gnt != 0 || cs_n !== 4'hF) regrant = 1'b1;
        end
        checks++; if (regrant !== 1'b0) begin errors++; $display("FAIL rd_no_regrant got %b exp 0", regrant); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slave();
`ifdef SPI_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_reset_mid();
        test_req_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
